// File: rtl/a7800_cart_pkg.sv
// Shared types and constants for the 7800 cartridge mapper: region codes,
// flag bit positions and the fetch FSM encoding.
package a7800_cart_pkg;
  localparam int FLAG_SG    = 0;
  localparam int FLAG_RAM   = 1;
  localparam int FLAG_BANK6 = 2;

  localparam int          BANK_SZ_LOG2  = 14;
  localparam int          BANK_W        = 4;
  localparam logic [7:0]  UNMAPPED_BYTE = 8'hFF;
  localparam logic [16:0] LIN_MAX_SIZE  = 17'h0C000;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_ROM_FIXED,
    REG_ROM_BANKED,
    REG_RAM,
    REG_ROM_B6
  } region_e;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } fetch_state_e;

  function automatic logic is_rom(input region_e r);
    return (r == REG_ROM_FIXED) || (r == REG_ROM_BANKED) || (r == REG_ROM_B6);
  endfunction
endpackage

// File: rtl/cart_region_decode.sv
// Combinational cartridge window decode: classifies a bus address and forms
// the ROM byte address for SuperGame or linear images.
module cart_region_decode
  import a7800_cart_pkg::*;
#(
  parameter int ROM_AW = 18
) (
  input  logic [15:0]        i_addr,
  input  logic [9:0]         i_flags,
  input  logic [31:0]        i_size,
  input  logic [BANK_W-1:0]  i_bank,
  output region_e            o_region,
  output logic [ROM_AW-1:0]  o_rom_addr
);
  localparam int NBW = ROM_AW - BANK_SZ_LOG2;

  logic [NBW-1:0]    w_nb_raw;
  logic [ROM_AW-1:0] w_nb;
  logic [ROM_AW-1:0] w_last;
  logic [ROM_AW-1:0] w_bank_mod;
  logic [ROM_AW-1:0] w_off;
  logic [16:0]       w_lin_size;
  logic [16:0]       w_lin_base;
  logic [16:0]       w_addr_x;
  logic              w_unused_flags;

  // An empty bank-count field means a single bank, so "last" is bank 0.
  assign w_nb_raw   = i_size[ROM_AW-1:BANK_SZ_LOG2];
  assign w_nb       = (w_nb_raw == '0) ? ROM_AW'(1) : ROM_AW'(w_nb_raw);
  assign w_last     = w_nb - ROM_AW'(1);
  assign w_bank_mod = ROM_AW'(i_bank) % w_nb;
  assign w_off      = ROM_AW'(i_addr[BANK_SZ_LOG2-1:0]);

  // Linear images sit flush against $FFFF; anything over 48 KB is clamped.
  assign w_lin_size = (i_size > 32'(LIN_MAX_SIZE)) ? LIN_MAX_SIZE : i_size[16:0];
  assign w_lin_base = 17'h10000 - w_lin_size;
  assign w_addr_x   = {1'b0, i_addr};

  assign w_unused_flags = ^i_flags[9:3];

  always_comb begin
    o_region   = REG_NONE;
    o_rom_addr = '0;
    if (i_flags[FLAG_SG]) begin
      case (i_addr[15:14])
        2'b11: begin
          o_region   = REG_ROM_FIXED;
          o_rom_addr = (w_last << BANK_SZ_LOG2) | w_off;
        end
        2'b10: begin
          o_region   = REG_ROM_BANKED;
          o_rom_addr = (w_bank_mod << BANK_SZ_LOG2) | w_off;
        end
        2'b01: begin
          if (i_flags[FLAG_RAM]) begin
            o_region = REG_RAM;
          end else if (i_flags[FLAG_BANK6]) begin
            o_region   = REG_ROM_B6;
            o_rom_addr = (ROM_AW'(6) << BANK_SZ_LOG2) | w_off;
          end
        end
        default: ;
      endcase
    end else if (w_addr_x >= w_lin_base) begin
      o_region   = REG_ROM_FIXED;
      o_rom_addr = ROM_AW'(w_addr_x - w_lin_base);
    end
  end
endmodule

// File: rtl/cart_mapper.sv
// 7800 cartridge mapper: SuperGame bank register, optional cart RAM and a
// single-outstanding ROM fetch FSM returning the cart data-bus byte.
module cart_mapper
  import a7800_cart_pkg::*;
#(
  parameter int ROM_AW      = 18,
  parameter int RAM_AW      = 14,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic               memclk,
  input  logic               reset,
  input  logic               i_cs,
  input  logic               i_rw,
  input  logic [15:0]        i_addr,
  input  logic [7:0]         i_din,
  input  logic [9:0]         i_cart_flags,
  input  logic [31:0]        i_cart_size,
  output logic               o_rom_req,
  output logic [ROM_AW-1:0]  o_rom_addr,
  input  logic               i_rom_ack,
  input  logic [7:0]         i_rom_data,
  output logic [7:0]         o_dout,
  output logic [BANK_W-1:0]  o_bank,
  output logic               o_miss,
  output fetch_state_e       o_state
);
  localparam int              CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  fetch_state_e      r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rom_req;
  logic [ROM_AW-1:0] r_rom_addr;
  logic [BANK_W-1:0] r_bank;
  logic              r_miss;
  logic [7:0]        r_dout;
  logic              r_ram_sel;
  logic [7:0]        r_ram_q;
  logic [7:0]        r_ram [0:(2**RAM_AW)-1];

  region_e           w_region;
  logic [ROM_AW-1:0] w_dec_addr;
  logic w_rd, w_wr, w_issue, w_done, w_tmo, w_drop, w_ram_rd, w_unmap_rd;
  logic w_bank_we, w_ram_we;

  cart_region_decode #(.ROM_AW(ROM_AW)) u_decode (
    .i_addr     (i_addr),
    .i_flags    (i_cart_flags),
    .i_size     (i_cart_size),
    .i_bank     (r_bank),
    .o_region   (w_region),
    .o_rom_addr (w_dec_addr)
  );

  assign w_rd      = i_cs & i_rw;
  assign w_wr      = i_cs & ~i_rw;
  assign w_bank_we = w_wr & (w_region == REG_ROM_BANKED);
  assign w_ram_we  = w_wr & (w_region == REG_RAM);

  // Fetch handshake: o_rom_req is a one-cycle pulse with o_rom_addr held from
  // then on; the store answers with i_rom_ack plus i_rom_data in one cycle, as
  // early as the request cycle itself. Only one fetch is ever outstanding.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_done       = 1'b0;
    w_tmo        = 1'b0;
    w_drop       = 1'b0;
    w_ram_rd     = 1'b0;
    w_unmap_rd   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rd) begin
          if (is_rom(w_region)) begin
            w_issue      = 1'b1;
            w_state_next = ST_WAIT;
          end else if (w_region == REG_RAM) begin
            w_ram_rd = 1'b1;
          end else begin
            w_unmap_rd = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        w_drop = w_rd;
        if (i_rom_ack) begin
          w_done       = 1'b1;
          w_state_next = ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_tmo        = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge memclk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge memclk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_rom_req  <= 1'b0;
      r_rom_addr <= '0;
      r_bank     <= '0;
      r_miss     <= 1'b0;
      r_dout     <= UNMAPPED_BYTE;
      r_ram_sel  <= 1'b0;
    end else begin
      r_rom_req <= w_issue;
      if (w_issue) begin
        r_rom_addr <= w_dec_addr;
        r_cnt      <= '0;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_bank_we) r_bank <= i_din[BANK_W-1:0];
      if (w_tmo || w_drop) r_miss <= 1'b1;
      if (w_done) begin
        r_dout    <= i_rom_data;
        r_ram_sel <= 1'b0;
      end else if (w_tmo || w_unmap_rd) begin
        r_dout    <= UNMAPPED_BYTE;
        r_ram_sel <= 1'b0;
      end else if (w_ram_rd) begin
        r_ram_sel <= 1'b1;
      end
    end
  end

  // Cart RAM keeps its contents across reset; reads land in r_ram_q one edge later.
  always_ff @(posedge memclk) begin
    if (w_ram_we) r_ram[i_addr[RAM_AW-1:0]] <= i_din;
    if (w_ram_rd) r_ram_q <= r_ram[i_addr[RAM_AW-1:0]];
  end

  assign o_rom_req  = r_rom_req;
  assign o_rom_addr = r_rom_addr;
  assign o_dout     = r_ram_sel ? r_ram_q : r_dout;
  assign o_bank     = r_bank;
  assign o_miss     = r_miss;
  assign o_state    = r_state;
endmodule

// File: tb/tb_cart_mapper.sv
// Bench for cart_mapper: directed cases with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_cart_mapper;
  import a7800_cart_pkg::*;

  localparam int ACK_TIMEOUT = 4;

  logic         memclk = 1'b0;
  logic         reset;
  logic         cs, rw;
  logic [15:0]  addr;
  logic [7:0]   din;
  logic [9:0]   flags;
  logic [31:0]  size;
  logic         rom_req;
  logic [17:0]  rom_addr;
  logic         rom_ack;
  logic [7:0]   rom_data;
  logic [7:0]   dout;
  logic [3:0]   bank;
  logic         miss;
  fetch_state_e state;

  cart_mapper #(.ROM_AW(18), .RAM_AW(14), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .memclk       (memclk),
    .reset        (reset),
    .i_cs         (cs),
    .i_rw         (rw),
    .i_addr       (addr),
    .i_din        (din),
    .i_cart_flags (flags),
    .i_cart_size  (size),
    .o_rom_req    (rom_req),
    .o_rom_addr   (rom_addr),
    .i_rom_ack    (rom_ack),
    .i_rom_data   (rom_data),
    .o_dout       (dout),
    .o_bank       (bank),
    .o_miss       (miss),
    .o_state      (state)
  );

  // ---------------- clock / reset ----------------
  always #5 memclk = ~memclk;

  // ---------------- model state ----------------
  int         n_vec = 0;
  int         n_mis = 0;
  bit         chk_on = 1'b0;
  int         m_bank, m_dout, m_req, m_addr, m_miss, m_busy;
  logic [7:0] m_ram [int];
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bank = 0; m_dout = 8'hFF; m_req = 0; m_addr = 0; m_miss = 0; m_busy = 0;
    exp_q.delete();
  endtask

  // kind: 0 unmapped, 1 ROM (ra = byte offset in image), 2 cart RAM
  function automatic void model_map(input int a, output int kind, output int ra);
    int nb, s, base;
    kind = 0;
    ra   = 0;
    if (flags[0]) begin
      nb = (int'(size) / 16384) % 16;
      if (nb == 0) nb = 1;
      if (a >= 49152) begin
        kind = 1; ra = (nb - 1) * 16384 + a % 16384;
      end else if (a >= 32768) begin
        kind = 1; ra = (m_bank % nb) * 16384 + a % 16384;
      end else if (a >= 16384) begin
        if (flags[1]) kind = 2;
        else if (flags[2]) begin kind = 1; ra = 6 * 16384 + a % 16384; end
      end
    end else begin
      s = (size > 32'd49152) ? 49152 : int'(size);
      base = 65536 - s;
      if (a >= base) begin kind = 1; ra = a - base; end
    end
  endfunction

  // ---------------- scoreboard compare ----------------
  always @(negedge memclk) begin
    if (chk_on) begin
      chk("dout", dout, m_dout);
      chk("bank", bank, m_bank);
      chk("miss", miss, m_miss);
      chk("rom_req", rom_req, m_req);
      chk("rom_addr", rom_addr, m_addr);
      chk("busy", (state == ST_WAIT), m_busy);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge memclk);
    #1;
    rom_data = 8'($urandom);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  task automatic do_write(input int a, input int d);
    int k, ra;
    model_map(a, k, ra);
    cs = 1'b1; rw = 1'b0; addr = 16'(a); din = 8'(d);
    cycle();
    cs = 1'b0; rw = 1'b1;
    if (flags[0] && a >= 32768 && a < 49152) m_bank = d % 16;
    if (k == 2) m_ram[a % 16384] = 8'(d);
  endtask

  // d_ack = WAIT cycle index carrying rom_ack (>= ACK_TIMEOUT means never).
  // inj_kind 1 = bank write to $8000 with inj_v, 2 = read of inj_v, on WAIT cycle inj_k.
  task automatic do_read(input int a, input int d_ack, input int data,
                         input int inj_k, input int inj_kind, input int inj_v);
    int k, ra;
    model_map(a, k, ra);
    cs = 1'b1; rw = 1'b1; addr = 16'(a);
    cycle();
    cs = 1'b0;
    if (k == 0) begin
      m_dout = 8'hFF;
    end else if (k == 2) begin
      m_dout = m_ram.exists(a % 16384) ? int'(m_ram[a % 16384]) : 8'hFF;
    end else begin
      m_req = 1; m_busy = 1; m_addr = ra;
      exp_q.push_back((d_ack < ACK_TIMEOUT) ? 8'(data) : 8'hFF);
      for (int kk = 0; kk < ACK_TIMEOUT; kk++) begin
        if (kk == d_ack) begin rom_ack = 1'b1; rom_data = 8'(data); end
        if (kk == inj_k && inj_kind == 1) begin
          cs = 1'b1; rw = 1'b0; addr = 16'h8000; din = 8'(inj_v);
        end
        if (kk == inj_k && inj_kind == 2) begin
          cs = 1'b1; rw = 1'b1; addr = 16'(inj_v);
        end
        cycle();
        rom_ack = 1'b0; cs = 1'b0; rw = 1'b1;
        m_req = 0;
        if (kk == inj_k && inj_kind == 1 && flags[0]) m_bank = inj_v % 16;
        if (kk == inj_k && inj_kind == 2) m_miss = 1;
        if (kk == d_ack || kk == ACK_TIMEOUT - 1) begin
          m_dout = int'(exp_q.pop_front());
          m_busy = 0;
          if (kk != d_ack) m_miss = 1;
          break;
        end
      end
    end
  endtask

  task automatic rd(input int a, input int d_ack, input int data);
    do_read(a, d_ack, data, -1, 0, 0);
  endtask

  task automatic late_ack();
    rom_ack = 1'b1;
    cycle();
    rom_ack = 1'b0;
  endtask

  function automatic int pick_addr(input int a);
    if (flags[0] && flags[1] && a >= 16384 && a < 32768) return 16'h4000 + a % 16;
    return a;
  endfunction

  // ---------------- stimulus ----------------
  int cfg_flags [8] = '{1, 3, 5, 0, 0, 1, 7, 0};
  int cfg_size  [8] = '{131072, 65536, 98304, 32768, 8192, 262144, 49152, 131072};

  initial begin
    reset = 1'b1; cs = 1'b0; rw = 1'b1; addr = '0; din = '0;
    flags = 10'd1; size = 32'd131072; rom_ack = 1'b0; rom_data = '0;
    model_reset();
    repeat (2) @(posedge memclk);
    #1;
    chk_on = 1'b1;
    chk("rst_dout", dout, 8'hFF);
    chk("rst_bank", bank, 4'd0);
    chk("rst_miss", miss, 1'b0);
    chk("rst_req", rom_req, 1'b0);
    chk("rst_addr", rom_addr, 18'h0);
    reset = 1'b0;
    cycle();

    // SuperGame 128 KB: fixed bank and bank switching
    rd(16'hC000, 0, 8'hA5);
    chk("sg_fixed_addr", rom_addr, 18'h1C000);
    chk("sg_fixed_dout", dout, 8'hA5);
    do_write(16'h8000, 3);
    chk("bank_wr3", bank, 4'd3);
    rd(16'h8123, 0, 8'h11);
    chk("banked_addr", rom_addr, 18'h0C123);
    do_write(16'h8000, 9);
    rd(16'h8000, 1, 8'h22);
    chk("bank_mod_addr", rom_addr, 18'h04000);
    chk("bank_mod_dout", dout, 8'h22);

    // cart RAM and bank 6
    flags = 10'd3;
    do_write(16'h4010, 8'h5A);
    rd(16'h4010, 0, 0);
    chk("ram_dout", dout, 8'h5A);
    chk("ram_no_req", rom_req, 1'b0);
    flags = 10'd5;
    rd(16'h4000, 0, 8'h33);
    chk("b6_addr", rom_addr, 18'h18000);

    // linear 32 KB
    flags = 10'd0; size = 32'd32768;
    rd(16'h7FFF, 0, 0);
    chk("lin_unmapped", dout, 8'hFF);
    rd(16'h8000, 0, 8'h44);
    chk("lin_addr", rom_addr, 18'h0);
    chk("lin_dout", dout, 8'h44);

    // timeout, late ack, recovery with sticky miss
    flags = 10'd1; size = 32'd131072;
    rd(16'hC000, ACK_TIMEOUT, 8'h55);
    chk("to_miss", miss, 1'b1);
    chk("to_dout", dout, 8'hFF);
    chk("to_idle", state, ST_IDLE);
    late_ack();
    rd(16'hC004, 2, 8'h66);
    chk("after_to_dout", dout, 8'h66);
    chk("after_to_miss", miss, 1'b1);

    // reset in WAIT, then a stray ack
    do_write(16'h8000, 5);
    cs = 1'b1; rw = 1'b1; addr = 16'hC000;
    cycle();
    cs = 1'b0;
    m_req = 1; m_busy = 1; m_addr = 18'h1C000;
    chk("pre_rst_req", rom_req, 1'b1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_wait_state", state, ST_IDLE);
    chk("rst_wait_bank", bank, 4'd0);
    cycle();
    reset = 1'b0;
    rom_ack = 1'b1; rom_data = 8'h77;
    cycle();
    rom_ack = 1'b0;
    cycle();
    chk("stray_ack_dout", dout, 8'hFF);
    chk("stray_ack_miss", miss, 1'b0);

    // bank write during an in-flight fetch, and a dropped read
    do_write(16'h8000, 1);
    do_read(16'h8010, 2, 8'h88, 0, 1, 2);
    chk("inflight_addr", rom_addr, 18'h04010);
    chk("inflight_bank", bank, 4'd2);
    chk("inflight_dout", dout, 8'h88);
    rd(16'h8010, 0, 8'h99);
    chk("newbank_addr", rom_addr, 18'h08010);
    do_read(16'hC000, 1, 8'hAA, 0, 2, 16'hC100);
    chk("drop_miss", miss, 1'b1);
    chk("drop_dout", dout, 8'hAA);

    // randomized traffic across configurations
    for (int c = 0; c < 8; c++) begin
      flags = 10'(cfg_flags[c]);
      size  = 32'(cfg_size[c]);
      apply_reset();
      if (flags[0] && flags[1])
        for (int i = 0; i < 16; i++) do_write(16'h4000 + i, int'($urandom_range(0, 255)));
      for (int n = 0; n < 60; n++) begin
        int op;
        op = int'($urandom_range(0, 9));
        if (op <= 2) begin
          int a;
          a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(16'h8000, 16'hBFFF))
                                           : int'($urandom_range(0, 16'hFFFF));
          do_write(pick_addr(a), int'($urandom_range(0, 255)));
        end else if (op <= 8) begin
          int a, ik, kind;
          a = pick_addr(int'($urandom_range(0, 16'hFFFF)));
          kind = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
          ik = int'($urandom_range(0, ACK_TIMEOUT - 1));
          do_read(a, int'($urandom_range(0, ACK_TIMEOUT)), int'($urandom_range(0, 255)),
                  ik, kind, int'($urandom_range(0, 16'hFFFF)));
        end else begin
          late_ack();
        end
      end
    end

    cycle();
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
